// File: rtl/io_pkg.sv
// Shared widths and output-handshake state encoding for the CPU I/O stage.
package io_pkg;
  localparam int DATA_W     = 32;
  localparam int FIFO_DEPTH = 4;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);

  typedef enum logic {
    OUT_IDLE    = 1'b0,
    OUT_PENDING = 1'b1
  } out_state_e;
endpackage

// File: rtl/io_fifo.sv
// Synchronous FIFO with a combinational zero-on-empty head; push visible after one edge.
// Pushes are dropped when full and pops are ignored when empty.
module io_fifo #(
  parameter int W     = io_pkg::DATA_W,
  parameter int DEPTH = io_pkg::FIFO_DEPTH
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         empty_o,
  output logic         full_o
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  // Count carries one extra bit so a full FIFO never aliases to empty.
  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && do_push) mem_q[wr_ptr_q] <= data_i;
  end
endmodule

// File: rtl/io_port_unit.sv
// CPU I/O stage: buffered input port drained by the bus, output register offered by valid/ready.
// Output word visible one cycle after OutPort_In; a reload while still pending flags out_overrun.
module io_port_unit #(
  parameter int DATA_W     = io_pkg::DATA_W,
  parameter int FIFO_DEPTH = io_pkg::FIFO_DEPTH
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [DATA_W-1:0] BusMuxOut,
  input  logic              OutPort_In,
  input  logic              InPort_Out,
  output logic [DATA_W-1:0] InPort_Data,
  output logic              InPort_Empty,
  input  logic [DATA_W-1:0] in_dev_data,
  input  logic              in_dev_valid,
  output logic              in_dev_ready,
  output logic [DATA_W-1:0] out_dev_data,
  output logic              out_dev_valid,
  input  logic              out_dev_ready,
  output logic              out_overrun
);
  import io_pkg::*;

  logic              fifo_full;
  out_state_e        state_q;
  logic [DATA_W-1:0] out_data_q;
  logic              overrun_q;

  io_fifo #(
    .W     (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_in_fifo (
    .clk_i   (Clock),
    .rst_i   (Reset),
    .push_i  (in_dev_valid),
    .data_i  (in_dev_data),
    .pop_i   (InPort_Out),
    .head_o  (InPort_Data),
    .empty_o (InPort_Empty),
    .full_o  (fifo_full)
  );

  assign in_dev_ready  = !fifo_full;
  assign out_dev_data  = out_data_q;
  assign out_dev_valid = (state_q == OUT_PENDING);
  assign out_overrun   = overrun_q;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= OUT_IDLE;
      out_data_q <= '0;
      overrun_q  <= 1'b0;
    end else begin
      case (state_q)
        OUT_IDLE: begin
          if (OutPort_In) begin
            out_data_q <= BusMuxOut;
            state_q    <= OUT_PENDING;
          end
        end
        OUT_PENDING: begin
          // A reload on the acknowledge edge hands off cleanly: old word taken, new one pending.
          if (OutPort_In) begin
            out_data_q <= BusMuxOut;
            if (!out_dev_ready) overrun_q <= 1'b1;
          end else if (out_dev_ready) begin
            state_q <= OUT_IDLE;
          end
        end
        default: state_q <= OUT_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_io_port_unit.sv
// Scoreboard bench for io_port_unit: stimulus queues expected bus reads and consumer words,
// monitors compare them whenever a pop or an output handshake happens.
module tb_io_port_unit;
  logic        Clock = 1'b0;
  logic        Reset;
  logic [31:0] BusMuxOut;
  logic        OutPort_In;
  logic        InPort_Out;
  logic [31:0] InPort_Data;
  logic        InPort_Empty;
  logic [31:0] in_dev_data;
  logic        in_dev_valid;
  logic        in_dev_ready;
  logic [31:0] out_dev_data;
  logic        out_dev_valid;
  logic        out_dev_ready;
  logic        out_overrun;

  int errors = 0;
  int checks = 0;
  logic [31:0] in_exp[$];
  logic [31:0] out_exp[$];

  io_port_unit dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .BusMuxOut     (BusMuxOut),
    .OutPort_In    (OutPort_In),
    .InPort_Out    (InPort_Out),
    .InPort_Data   (InPort_Data),
    .InPort_Empty  (InPort_Empty),
    .in_dev_data   (in_dev_data),
    .in_dev_valid  (in_dev_valid),
    .in_dev_ready  (in_dev_ready),
    .out_dev_data  (out_dev_data),
    .out_dev_valid (out_dev_valid),
    .out_dev_ready (out_dev_ready),
    .out_overrun   (out_overrun)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Bus-side monitor: every pop strobe must see the predicted head.
  always @(negedge Clock) begin
    if (!Reset && InPort_Out) begin
      if (in_exp.size() == 0) chk("in_pop_unexpected", InPort_Data, 32'hFFFF_FFFF);
      else chk("in_pop_data", InPort_Data, in_exp.pop_front());
    end
  end

  // Consumer-side monitor: every accepted word must match the predicted one.
  always @(negedge Clock) begin
    if (!Reset && out_dev_valid && out_dev_ready) begin
      if (out_exp.size() == 0) chk("out_accept_unexpected", out_dev_data, 32'hFFFF_FFFF);
      else chk("out_accept_data", out_dev_data, out_exp.pop_front());
    end
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic at_neg();
    @(negedge Clock);
  endtask

  initial begin
    Reset = 1'b1; BusMuxOut = '0; OutPort_In = 1'b0; InPort_Out = 1'b0;
    in_dev_data = '0; in_dev_valid = 1'b0; out_dev_ready = 1'b0;
    step(); step();
    Reset = 1'b0;
    at_neg();
    chk("rst_empty", 32'(InPort_Empty), 32'd1);
    chk("rst_in_ready", 32'(in_dev_ready), 32'd1);
    chk("rst_out_valid", 32'(out_dev_valid), 32'd0);
    chk("rst_in_data", InPort_Data, 32'd0);
    chk("rst_out_data", out_dev_data, 32'd0);
    step();

    // Fill the FIFO with four words.
    for (int i = 0; i < 4; i++) begin
      in_dev_valid = 1'b1;
      in_dev_data  = 32'h11 * (i + 1);
      step();
    end
    in_dev_valid = 1'b0;
    at_neg();
    chk("full_ready_low", 32'(in_dev_ready), 32'd0);
    chk("full_not_empty", 32'(InPort_Empty), 32'd0);
    step();

    // Drain four words plus one pop on empty.
    in_exp.push_back(32'h11); in_exp.push_back(32'h22);
    in_exp.push_back(32'h33); in_exp.push_back(32'h44);
    in_exp.push_back(32'h0);
    InPort_Out = 1'b1;
    at_neg();
    chk("pop_while_full_ready", 32'(in_dev_ready), 32'd0);
    step();
    at_neg();
    chk("ready_after_pop", 32'(in_dev_ready), 32'd1);
    repeat (4) step();
    InPort_Out = 1'b0;
    at_neg();
    chk("drained_empty", 32'(InPort_Empty), 32'd1);
    chk("drained_data", InPort_Data, 32'd0);
    step();

    // Steady-state push+pop with one entry, covering pointer wrap.
    in_dev_valid = 1'b1; in_dev_data = 32'hA;
    step();
    for (int k = 0; k < 10; k++) begin
      in_dev_valid = 1'b1;
      in_dev_data  = 32'hB + k;
      InPort_Out   = 1'b1;
      in_exp.push_back(32'hA + k);
      at_neg();
      chk("stream_not_empty", 32'(InPort_Empty), 32'd0);
      step();
    end
    in_dev_valid = 1'b0;
    in_exp.push_back(32'h14);
    at_neg();
    chk("stream_count_one", 32'(InPort_Empty), 32'd0);
    step();
    InPort_Out = 1'b0;
    at_neg();
    chk("stream_final_empty", 32'(InPort_Empty), 32'd1);
    step();

    // Output word held pending for three cycles, then accepted.
    OutPort_In = 1'b1; BusMuxOut = 32'hDEAD_BEEF;
    step();
    OutPort_In = 1'b0; BusMuxOut = '0;
    for (int c = 0; c < 3; c++) begin
      at_neg();
      chk("out_valid_held", 32'(out_dev_valid), 32'd1);
      step();
    end
    out_dev_ready = 1'b1;
    out_exp.push_back(32'hDEAD_BEEF);
    at_neg();
    chk("out_valid_4th", 32'(out_dev_valid), 32'd1);
    step();
    out_dev_ready = 1'b0;
    at_neg();
    chk("out_valid_dropped", 32'(out_dev_valid), 32'd0);
    chk("out_data_kept", out_dev_data, 32'hDEAD_BEEF);
    chk("no_overrun_yet", 32'(out_overrun), 32'd0);
    step();

    // Reload on the acknowledge edge: no overrun; reload without ready: overrun.
    OutPort_In = 1'b1; BusMuxOut = 32'h5;
    step();
    BusMuxOut = 32'h6; out_dev_ready = 1'b1;
    out_exp.push_back(32'h5);
    step();
    OutPort_In = 1'b0; out_dev_ready = 1'b0;
    at_neg();
    chk("handoff_no_overrun", 32'(out_overrun), 32'd0);
    chk("handoff_valid", 32'(out_dev_valid), 32'd1);
    chk("handoff_data", out_dev_data, 32'h6);
    step();
    OutPort_In = 1'b1; BusMuxOut = 32'h7;
    step();
    OutPort_In = 1'b0;
    at_neg();
    chk("overrun_set", 32'(out_overrun), 32'd1);
    chk("overrun_data", out_dev_data, 32'h7);
    chk("overrun_valid", 32'(out_dev_valid), 32'd1);
    step();
    out_dev_ready = 1'b1;
    out_exp.push_back(32'h7);
    step();
    out_dev_ready = 1'b0;
    at_neg();
    chk("overrun_sticky", 32'(out_overrun), 32'd1);
    chk("final_ack_drop", 32'(out_dev_valid), 32'd0);
    step();

    // Reset with two buffered words, a pending output and a push in flight.
    in_dev_valid = 1'b1; in_dev_data = 32'h55;
    step();
    in_dev_data = 32'h66; OutPort_In = 1'b1; BusMuxOut = 32'h99;
    step();
    OutPort_In = 1'b0; in_dev_data = 32'h77; Reset = 1'b1;
    step();
    Reset = 1'b0; in_dev_valid = 1'b0;
    at_neg();
    chk("rst2_empty", 32'(InPort_Empty), 32'd1);
    chk("rst2_in_ready", 32'(in_dev_ready), 32'd1);
    chk("rst2_in_data", InPort_Data, 32'd0);
    chk("rst2_out_valid", 32'(out_dev_valid), 32'd0);
    chk("rst2_out_data", out_dev_data, 32'd0);
    chk("rst2_overrun", 32'(out_overrun), 32'd0);
    step();
    InPort_Out = 1'b1;
    in_exp.push_back(32'h0);
    step();
    InPort_Out = 1'b0;
    step();

    chk("in_queue_drained", 32'(in_exp.size()), 32'd0);
    chk("out_queue_drained", 32'(out_exp.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
